// File: rtl/controller_reader_pkg.sv
// rtl/controller_reader_pkg.sv - shared types and default timing constants for the game pad reader
package controller_reader_pkg;

    // Default half-period and poll interval, in system clock cycles
    localparam int DIV_DEFAULT  = 300;
    localparam int POLL_DEFAULT = 833333;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/controller_reader_pad_sync.sv
// rtl/controller_reader_pad_sync.sv - two-flop synchronizer for the asynchronous pad data line
module pad_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Resets to 1 because the idle (released) pad line reads high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/controller_reader.sv
// rtl/controller_reader.sv - periodic game pad poller producing a button byte and change interrupt
module controller_reader
    import controller_reader_pkg::*;
#(
    parameter int DIV  = DIV_DEFAULT,
    parameter int POLL = POLL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] controller_data,
    output logic       data_valid,
    output logic       change_irq
);

    // Divider must reach 2*DIV-1 for the latch phase; poll counter reaches POLL-1
    localparam int DW = $clog2(2 * DIV);
    localparam int PW = $clog2(POLL);

    localparam logic [DW-1:0] LATCH_LAST = DW'(2 * DIV - 1);
    localparam logic [DW-1:0] HALF_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE    = DW'(1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL - 1);
    localparam logic [PW-1:0] POLL_ONE   = PW'(1);

    // A frame must fit between two poll strobes, otherwise frames would be skipped forever
    if (DIV < 4 || DIV > 65535) begin : g_div_check
        $error("controller_reader: DIV must be in 4..65535");
    end
    if (POLL <= 17 * DIV + 1) begin : g_poll_check
        $error("controller_reader: POLL must exceed 17*DIV+1");
    end

    logic          pad_s;
    logic [PW-1:0] poll_q;
    logic          poll_strobe;
    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          pad_latch_q;
    logic          pad_clk_q;
    logic [7:0]    controller_data_q;
    logic          data_valid_q;
    logic          change_irq_q;

    pad_sync u_pad_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (pad_data),
        .q_o    (pad_s)
    );

    // Free-running poll counter; its wrap cycle is the frame start opportunity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_q <= '0;
        end else if (poll_q == POLL_LAST) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + POLL_ONE;
        end
    end

    assign poll_strobe = (poll_q == POLL_LAST);

    // Shift register image with the current bit replaced by the synchronized pad line
    always_comb begin
        shift_d        = shift_q;
        shift_d[bit_q] = pad_s;
    end

    // Frame sequencer: latch pulse, eight sample slots separated by seven clock pulses, result cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            div_q             <= '0;
            bit_q             <= 3'd0;
            shift_q           <= 8'hFF;
            pad_latch_q       <= 1'b0;
            pad_clk_q         <= 1'b0;
            controller_data_q <= 8'h00;
            data_valid_q      <= 1'b0;
            change_irq_q      <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            change_irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (poll_strobe && enable) begin
                        state_q     <= ST_LATCH;
                        div_q       <= '0;
                        pad_latch_q <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_q == LATCH_LAST) begin
                        state_q     <= ST_LOW;
                        div_q       <= '0;
                        bit_q       <= 3'd0;
                        pad_latch_q <= 1'b0;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_LOW: begin
                    if (div_q == HALF_LAST) begin
                        shift_q <= shift_d;
                        div_q   <= '0;
                        if (bit_q == 3'd7) begin
                            // Pad line is active-low; report 1 = pressed
                            state_q           <= ST_DONE;
                            controller_data_q <= ~shift_d;
                            data_valid_q      <= 1'b1;
                            change_irq_q      <= (~shift_d != controller_data_q);
                        end else begin
                            state_q   <= ST_HIGH;
                            pad_clk_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_HIGH: begin
                    if (div_q == HALF_LAST) begin
                        state_q   <= ST_LOW;
                        div_q     <= '0;
                        bit_q     <= bit_q + 3'd1;
                        pad_clk_q <= 1'b0;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    div_q   <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    div_q       <= '0;
                    pad_latch_q <= 1'b0;
                    pad_clk_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pad_latch       = pad_latch_q;
    assign pad_clk         = pad_clk_q;
    assign controller_data = controller_data_q;
    assign data_valid      = data_valid_q;
    assign change_irq      = change_irq_q;

endmodule

// File: tb/tb_controller_reader.sv
// tb/tb_controller_reader.sv - directed self-checking bench for controller_reader
module tb_controller_reader;

    localparam int DIV  = 4;
    localparam int POLL = 200;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] controller_data;
    logic       data_valid;
    logic       change_irq;

    logic [7:0] pattern  = 8'hA5;
    logic [2:0] idx      = 3'd0;
    int         pad_mode = 0;
    int         cyc      = 0;
    int         total    = 0;
    int         bad      = 0;

    controller_reader #(
        .DIV  (DIV),
        .POLL (POLL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .pad_data        (pad_data),
        .pad_latch       (pad_latch),
        .pad_clk         (pad_clk),
        .controller_data (controller_data),
        .data_valid      (data_valid),
        .change_irq      (change_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch presents bit0, each rising pad_clk advances to the next bit
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) idx <= 3'd0;
        else if (idx != 3'd7) idx <= idx + 3'd1;
    end

    assign pad_data = (pad_mode == 1) ? 1'b1 :
                      (pad_mode == 2) ? 1'b0 : ~pattern[idx];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Waits for a frame start, then measures it through its data_valid cycle
    task automatic run_frame(output int ok, output int start, output int len, output int lat,
                             output int pulses, output int hi, output logic [7:0] data,
                             output logic irq);
        int   n;
        logic prev;
        ok = 1; start = 0; len = 0; lat = 0; pulses = 0; hi = 0; data = 8'h00; irq = 1'b0;
        @(negedge clk);
        n = 0;
        while (!pad_latch && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!pad_latch) begin
            ok = 0;
            return;
        end
        start = cyc;
        prev  = 1'b0;
        n     = 0;
        while (n < 2000) begin
            len++;
            if (pad_latch) lat++;
            if (pad_clk) hi++;
            if (pad_clk && !prev) pulses++;
            prev = pad_clk;
            if (data_valid) begin
                data = controller_data;
                irq  = change_irq;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!data_valid) ok = 0;
    endtask

    initial begin
        int         ok, s1, s2, len, lat, pulses, hi, n, cnt, falls;
        logic [7:0] data;
        logic       irq, prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_latch", pad_latch, 0);
        check("rst_padclk", pad_clk, 0);
        check("rst_data", controller_data, 8'h00);
        check("rst_dv", data_valid, 0);
        check("rst_irq", change_irq, 0);
        reset = 1'b1;

        // enable low from reset: no frames
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pad_latch || data_valid) cnt++;
        end
        check("dis_no_latch", cnt, 0);

        // First frame 0xA5 with full waveform timing
        enable   = 1'b1;
        pattern  = 8'hA5;
        run_frame(ok, s1, len, lat, pulses, hi, data, irq);
        check("f1_ok", ok, 1);
        check("f1_data", data, 8'hA5);
        check("f1_irq", irq, 1);
        check("f1_len", len, 69);
        check("f1_latch_len", lat, 8);
        check("f1_pulses", pulses, 7);
        check("f1_clk_hi", hi, 28);
        @(negedge clk);
        check("f1_dv_1cyc", data_valid, 0);
        check("f1_irq_1cyc", change_irq, 0);

        // Same byte again: no change interrupt, frames 200 cycles apart
        run_frame(ok, s2, len, lat, pulses, hi, data, irq);
        check("f2_ok", ok, 1);
        check("f2_data", data, 8'hA5);
        check("f2_irq", irq, 0);
        check("f2_spacing", s2 - s1, POLL);
        @(negedge clk);
        check("f2_hold", controller_data, 8'hA5);

        // New byte 0x5A
        pattern = 8'h5A;
        run_frame(ok, s1, len, lat, pulses, hi, data, irq);
        check("f3_ok", ok, 1);
        check("f3_data", data, 8'h5A);
        check("f3_irq", irq, 1);
        check("f3_spacing", s1 - s2, POLL);
        check("f3_len", len, 69);
        @(negedge clk);
        check("f3_irq_1cyc", change_irq, 0);

        // Line stuck high: nothing pressed
        pad_mode = 1;
        run_frame(ok, s1, len, lat, pulses, hi, data, irq);
        check("st1_data", data, 8'h00);
        check("st1_irq", irq, 1);

        // Line stuck low: everything pressed, interrupt only on the transition frame
        pad_mode = 2;
        run_frame(ok, s1, len, lat, pulses, hi, data, irq);
        check("st0_data", data, 8'hFF);
        check("st0_irq", irq, 1);
        run_frame(ok, s1, len, lat, pulses, hi, data, irq);
        check("st0b_data", data, 8'hFF);
        check("st0b_irq", irq, 0);

        // enable dropped during HIGH: frame completes, then no more frames
        pad_mode = 0;
        pattern  = 8'h3C;
        n = 0;
        @(negedge clk);
        while (!pad_clk && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("en_drop_in_high", pad_clk, 1);
        enable = 1'b0;
        n = 0;
        while (!data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("en_drop_dv", data_valid, 1);
        check("en_drop_data", controller_data, 8'h3C);
        cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (pad_latch) cnt++;
        end
        check("en_drop_no_more", cnt, 0);

        // Reset during LOW at bit 3
        enable  = 1'b1;
        pattern = 8'h81;
        n = 0;
        while (!pad_latch && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rf_latch_seen", pad_latch, 1);
        falls = 0;
        prev  = 1'b0;
        n     = 0;
        while (falls < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (prev && !pad_clk) falls++;
            prev = pad_clk;
        end
        check("rf_bit3_reached", falls, 3);
        @(negedge clk);
        check("rf_pre_data", controller_data, 8'h3C);
        #2 reset = 1'b0;
        #1;
        check("rf_async_data", controller_data, 8'h00);
        check("rf_async_latch", pad_latch, 0);
        check("rf_async_clk", pad_clk, 0);
        check("rf_async_dv", data_valid, 0);
        check("rf_async_irq", change_irq, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_valid) cnt++;
        end
        reset = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (data_valid) cnt++;
            if (pad_latch) break;
        end
        check("rf_restart_delay", n, POLL);
        check("rf_no_dv", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
